// File: rtl/signed_div.sv
// Sequential signed multiply/divide unit: restoring divide (64/32) or shift-add multiply (32x32),
// one iteration per clock, operands handled as unsigned magnitudes with signs reapplied at completion.
module signed_div (
    output logic [63:0] result,
    output logic        valid,
    input  logic [31:0] opera1,
    input  logic [63:0] opera2,
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        muordi
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [6:0]  cnt;
    logic        mode;
    logic        neg_q;
    logic        neg_r;
    logic        neg_p;
    logic        div_zero;
    logic [31:0] dz_low;

    logic [63:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    logic [63:0] dvd_abs;
    logic [31:0] op1_abs;
    logic [31:0] op2lo_abs;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_next;
    logic [63:0] quo_signed;
    logic [31:0] rem_signed;
    logic [63:0] prod_signed;
    logic [6:0]  last_cnt;

    // Magnitudes of the extreme negatives (-2^63, -2^31) are still exact as unsigned values.
    assign dvd_abs   = opera2[63] ? (~opera2 + 64'd1) : opera2;
    assign op1_abs   = opera1[31] ? (~opera1 + 32'd1) : opera1;
    assign op2lo_abs = opera2[31] ? (~opera2[31:0] + 32'd1) : opera2[31:0];

    assign rem_sh   = {rem, quo[63]};
    assign fits     = rem_sh >= {1'b0, dvs};
    // A restored remainder is always below the divisor, so the low 32 bits of the difference are exact.
    assign rem_next = fits ? (rem_sh[31:0] - dvs) : rem_sh[31:0];

    assign quo_signed  = neg_q ? (~quo + 64'd1) : quo;
    assign rem_signed  = neg_r ? (~rem + 32'd1) : rem;
    assign prod_signed = neg_p ? (~acc + 64'd1) : acc;
    assign last_cnt    = mode ? 7'd64 : 7'd32;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            result   <= 64'd0;
            valid    <= 1'b0;
            cnt      <= 7'd0;
            mode     <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            neg_p    <= 1'b0;
            div_zero <= 1'b0;
            dz_low   <= 32'd0;
            quo      <= 64'd0;
            rem      <= 32'd0;
            dvs      <= 32'd0;
            acc      <= 64'd0;
            mcand    <= 64'd0;
            mplier   <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode     <= muordi;
                        neg_q    <= opera2[63] ^ opera1[31];
                        neg_r    <= opera2[63];
                        neg_p    <= opera2[31] ^ opera1[31];
                        div_zero <= (opera1 == 32'd0);
                        dz_low   <= opera2[31:0];
                        quo      <= dvd_abs;
                        rem      <= 32'd0;
                        dvs      <= op1_abs;
                        acc      <= 64'd0;
                        mcand    <= {32'd0, op1_abs};
                        mplier   <= op2lo_abs;
                        cnt      <= 7'd0;
                        valid    <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == last_cnt) begin
                        if (!mode)
                            result <= prod_signed;
                        else if (div_zero)
                            result <= {dz_low, 32'hFFFF_FFFF};
                        else
                            result <= {rem_signed, quo_signed[31:0]};
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 7'd1;
                        if (mode) begin
                            rem <= rem_next;
                            quo <= {quo[62:0], fits};
                        end else begin
                            if (mplier[0])
                                acc <= acc + mcand;
                            mcand  <= {mcand[62:0], 1'b0};
                            mplier <= {1'b0, mplier[31:1]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div.sv
// Self-checking bench for signed_div: directed corner cases, mid-operation reset,
// and random signed divides/multiplies against a plain-arithmetic reference model.
module tb_signed_div;

    logic [63:0] result;
    logic        valid;
    logic [31:0] opera1;
    logic [63:0] opera2;
    logic        clock;
    logic        reset;
    logic        start;
    logic        muordi;

    int          total;
    int          bad;
    logic [63:0] last_result;

    signed_div dut (
        .result(result),
        .valid (valid),
        .opera1(opera1),
        .opera2(opera2),
        .clock (clock),
        .reset (reset),
        .start (start),
        .muordi(muordi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference built from the arithmetic rules, using the simulator's own truncating / and %.
    function automatic logic [63:0] refModel(input bit mode, input logic [31:0] a, input logic [63:0] b);
        longint n;
        longint d;
        longint q;
        longint r;
        longint x;
        longint y;
        if (!mode) begin
            x = $signed(a);
            y = $signed(b[31:0]);
            return x * y;
        end
        if (a == 32'd0)
            return {b[31:0], 32'hFFFF_FFFF};
        n = b;
        d = $signed(a);
        if (n == 64'sh8000_0000_0000_0000 && d == -1)
            return 64'd0;
        q = n / d;
        r = n % d;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic applyStimulus(input bit mode, input logic [31:0] a, input logic [63:0] b,
                                 input logic [63:0] exp, input string tag, input bit poke);
        int lat;
        lat = mode ? 65 : 33;
        @(negedge clock);
        muordi = mode;
        opera1 = a;
        opera2 = b;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        opera1 = $urandom;
        opera2 = {$urandom, $urandom};
        muordi = 1'($urandom);
        checkOutput({tag, "_vlow"}, {63'd0, valid}, 64'd0);
        checkOutput({tag, "_hold"}, result, last_result);
        for (int i = 1; i < lat; i++) begin
            if (poke && i == 20) start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        checkOutput({tag, "_early"}, {63'd0, valid}, 64'd0);
        @(negedge clock);
        checkOutput({tag, "_valid"}, {63'd0, valid}, 64'd1);
        checkOutput({tag, "_result"}, result, exp);
        last_result = exp;
        repeat (6) @(negedge clock);
        checkOutput({tag, "_stable"}, result, exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        longint      n;
        longint      d;
        longint      qe;
        longint      qo;
        longint      ro;
        bit          mode;

        total = 0;
        bad = 0;
        last_result = 64'd0;
        start = 1'b0;
        muordi = 1'b0;
        opera1 = 32'd0;
        opera2 = 64'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_valid", {63'd0, valid}, 64'd0);
        checkOutput("reset_result", result, 64'd0);
        reset = 1'b0;

        applyStimulus(1'b1, 32'd7, 64'd100, 64'h00000002_0000000E, "div_100_7", 1'b0);
        applyStimulus(1'b1, 32'd7, -64'd100, 64'hFFFFFFFE_FFFFFFF2, "div_m100_7", 1'b0);
        applyStimulus(1'b1, -32'd7, 64'd100, 64'h00000002_FFFFFFF2, "div_100_m7", 1'b0);
        applyStimulus(1'b1, 32'd1, 64'h00000001_00000005, 64'h00000000_00000005, "div_wrap", 1'b0);
        applyStimulus(1'b1, 32'd0, 64'd100, 64'h00000064_FFFFFFFF, "div_zero", 1'b0);
        applyStimulus(1'b1, 32'd3, 64'h80000000_00000000, 64'hFFFFFFFE_55555556, "div_min_3", 1'b0);
        applyStimulus(1'b1, 32'h80000000, 64'h80000000_00000000, 64'd0, "div_min_min", 1'b0);
        applyStimulus(1'b0, -32'd3, 64'd5, 64'hFFFFFFFF_FFFFFFF1, "mul_m3_5", 1'b0);
        applyStimulus(1'b0, 32'h80000000, 64'h00000000_80000000, 64'h40000000_00000000, "mul_min_min", 1'b0);
        applyStimulus(1'b0, 32'd7, 64'hDEADBEEF_00000006, 64'd42, "mul_upper_ignored", 1'b0);

        // Abort a divide mid-flight, then confirm a fresh one runs to completion.
        @(negedge clock);
        muordi = 1'b1;
        opera1 = 32'd9;
        opera2 = 64'd1000;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort_valid", {63'd0, valid}, 64'd0);
        checkOutput("abort_result", result, 64'd0);
        last_result = 64'd0;
        applyStimulus(1'b1, 32'd9, 64'd1000, 64'h00000001_0000006F, "after_abort", 1'b0);

        for (int k = 0; k < 40; k++) begin
            mode = (k % 5) != 4;
            case ($urandom_range(0, 3))
                0: b = {$urandom, $urandom};
                1: b = {{32{1'b0}}, 32'($urandom)};
                2: b = 64'h80000000_00000000;
                default: b = {{16{1'b1}}, 16'($urandom), 32'($urandom)};
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            case ($urandom_range(0, 4))
                0: a = $urandom;
                1: a = 32'($urandom_range(1, 1000));
                2: a = -32'($urandom_range(1, 1000));
                3: a = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
                default: a = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
            endcase
            exp = refModel(mode, a, b);
            applyStimulus(mode, a, b, exp, mode ? "rand_div" : "rand_mul", 1'b1);
            if (mode && a != 32'd0) begin
                n = b;
                d = $signed(a);
                if (!(n == 64'sh8000_0000_0000_0000 && d == -1)) begin
                    qe = n / d;
                    if (qe >= -64'sd2147483648 && qe <= 64'sd2147483647) begin
                        qo = $signed(result[31:0]);
                        ro = $signed(result[63:32]);
                        checkOutput("rand_identity", qo * d + ro, b);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
